// File: rtl/accumulator_n_bits_mode.sv
// N-bit registered accumulator (add/sub/load/clear, wrap or signed saturation) with
// carry/overflow flags and op counter; 1-cycle latency, accepts every cycle, no backpressure.
module accumulator_n_bits_mode #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [1:0]    op,
  input  logic          sat_en,
  input  logic [N-1:0]  in_data,
  output logic [N-1:0]  acc,
  output logic          cout,
  output logic          ovf,
  output logic          ovf_sticky,
  output logic [CW-1:0] cnt,
  output logic          out_valid
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   full;
  logic [N-1:0] sum;
  logic         ovf_now;
  logic [N-1:0] sat_val;
  logic [N-1:0] arith_res;

  // SUB is two's-complement add of ~B with carry-in 1, so one adder serves both.
  always_comb begin
    is_sub    = (op == OP_SUB);
    b_eff     = is_sub ? ~in_data : in_data;
    full      = {1'b0, acc} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
    sum       = full[N-1:0];
    ovf_now   = (acc[N-1] == b_eff[N-1]) && (sum[N-1] != acc[N-1]);
    sat_val   = acc[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    arith_res = (sat_en && ovf_now) ? sat_val : sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        case (op)
          OP_ADD, OP_SUB: begin
            acc        <= arith_res;
            cout       <= full[N];
            ovf        <= ovf_now;
            ovf_sticky <= ovf_sticky | ovf_now;
            cnt        <= cnt + CW'(1);
          end
          OP_LOAD: begin
            acc  <= in_data;
            cout <= 1'b0;
            ovf  <= 1'b0;
            cnt  <= '0;
          end
          OP_CLEAR: begin
            acc        <= '0;
            cout       <= 1'b0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accumulator_n_bits_mode.sv
// Directed-vector bench for accumulator_n_bits_mode with N=8, CW=2.
module tb_accumulator_n_bits_mode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] op;
  logic       sat_en;
  logic [7:0] in_data;
  logic [7:0] acc;
  logic       cout;
  logic       ovf;
  logic       ovf_sticky;
  logic [1:0] cnt;
  logic       out_valid;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  accumulator_n_bits_mode #(.N(8), .CW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .sat_en(sat_en),
    .in_data(in_data), .acc(acc), .cout(cout), .ovf(ovf), .ovf_sticky(ovf_sticky),
    .cnt(cnt), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operation for one edge, then sample 1 time unit after that edge.
  task automatic apply(input logic [1:0] o, input logic [7:0] d, input logic s);
    in_valid = 1'b1;
    op       = o;
    in_data  = d;
    sat_en   = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [1:0] exp_cnt [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
  int pulses;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = ADD; sat_en = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_outv", out_valid, 0);
    rst_n = 1'b1;

    // Reset mid-operation
    apply(ADD, 8'h05, 1'b0);
    apply(ADD, 8'h05, 1'b0);
    chk("add2_acc", acc, 8'h0A);
    chk("add2_cnt", cnt, 2);
    chk("add2_outv", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_outv", out_valid, 0);
    #1 rst_n = 1'b1;
    apply(ADD, 8'h03, 1'b0);
    chk("post_rst_acc", acc, 8'h03);
    chk("post_rst_cnt", cnt, 1);
    chk("post_rst_outv", out_valid, 1);

    // Wrap overflow
    apply(LOAD, 8'h7F, 1'b0);
    chk("load_acc", acc, 8'h7F);
    chk("load_cnt", cnt, 0);
    apply(ADD, 8'h01, 1'b0);
    chk("wrap_acc", acc, 8'h80);
    chk("wrap_ovf", ovf, 1);
    chk("wrap_cout", cout, 0);
    chk("wrap_sticky", ovf_sticky, 1);
    chk("wrap_cnt", cnt, 1);

    // Saturation, positive then negative, repeated at the limit
    apply(CLR, 8'hAA, 1'b0);
    chk("clr_sticky", ovf_sticky, 0);
    apply(LOAD, 8'h7F, 1'b1);
    apply(ADD, 8'h01, 1'b1);
    chk("satp_acc", acc, 8'h7F);
    chk("satp_ovf", ovf, 1);
    chk("satp_cout", cout, 0);
    apply(ADD, 8'h01, 1'b1);
    chk("satp2_acc", acc, 8'h7F);
    chk("satp2_ovf", ovf, 1);
    apply(LOAD, 8'h80, 1'b1);
    apply(SUB, 8'h01, 1'b1);
    chk("satn_acc", acc, 8'h80);
    chk("satn_ovf", ovf, 1);
    chk("satn_cout", cout, 1);

    // 0 - 0
    apply(CLR, 8'h00, 1'b0);
    apply(SUB, 8'h00, 1'b0);
    chk("sub00_acc", acc, 0);
    chk("sub00_cout", cout, 1);
    chk("sub00_ovf", ovf, 0);

    // Borrow without overflow
    apply(CLR, 8'h00, 1'b0);
    apply(SUB, 8'h01, 1'b0);
    chk("borrow_acc", acc, 8'hFF);
    chk("borrow_cout", cout, 0);
    chk("borrow_ovf", ovf, 0);
    chk("borrow_sticky", ovf_sticky, 0);
    chk("borrow_cnt", cnt, 1);

    // Sticky flag and 2-bit counter wrap
    apply(CLR, 8'h00, 1'b0);
    apply(LOAD, 8'h7F, 1'b0);
    apply(ADD, 8'h01, 1'b0);
    chk("stk_ovf", ovf, 1);
    chk("stk_cnt1", cnt, 1);
    for (int i = 0; i < 4; i++) begin
      apply(ADD, 8'h01, 1'b0);
      chk("stk_loop_ovf", ovf, 0);
      chk("stk_loop_sticky", ovf_sticky, 1);
      chk("stk_loop_cnt", cnt, exp_cnt[i]);
    end
    chk("stk_acc", acc, 8'h84);
    apply(LOAD, 8'h10, 1'b0);
    chk("stk_load_sticky", ovf_sticky, 1);
    chk("stk_load_cnt", cnt, 0);
    apply(CLR, 8'h00, 1'b0);
    chk("stk_clr_sticky", ovf_sticky, 0);

    // Handshake: alternate valid; idle cycles carry a CLEAR that must be ignored
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      op       = (i % 2 == 0) ? ADD : CLR;
      in_data  = (i % 2 == 0) ? 8'h01 : 8'h55;
      sat_en   = 1'b0;
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
      chk("hs_outv", out_valid, (i % 2 == 0) ? 1 : 0);
      chk("hs_acc", acc, i / 2 + 1);
    end
    in_valid = 1'b0;
    chk("hs_pulses", pulses, 3);
    @(posedge clk);
    #1;
    chk("hs_idle_acc", acc, 8'h03);
    chk("hs_idle_outv", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
